// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM encoding and derived timing constants.
package alu_pkg;
  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
endpackage

// File: rtl/nr_div_step.sv
// One combinational non-restoring division iteration on the {A,Q} pair.
module nr_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH:0] w_shift_a;

  // The add/subtract choice follows the sign of A before the shift; with A in
  // [-M, M) the shifted value still fits WIDTH+1 signed bits, so both agree.
  always_comb begin
    w_shift_a = {i_a[WIDTH-1:0], i_q[WIDTH-1]};
    if (!i_a[WIDTH]) o_a = w_shift_a - i_m;
    else             o_a = w_shift_a + i_m;
    o_q = {i_q[WIDTH-2:0], ~o_a[WIDTH]};
  end
endmodule

// File: rtl/divider_32b.sv
// Sequential signed divider, one quotient bit per clock; start/busy/done handshake.
module divider_32b
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output div_state_t       o_state
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       r_state, w_next;
  logic [WIDTH:0]   r_a, r_m, w_step_a;
  logic [WIDTH-1:0] r_q, w_step_q, w_dvd_abs, w_dvs_abs, w_rem_mag;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q, r_neg_r;
  logic [WIDTH-1:0] r_quot, r_rem;
  logic             r_busy, r_done, r_dbz;
  logic             w_busy_nxt, w_done_nxt;

  nr_div_step #(.WIDTH(WIDTH)) u_step (
    .i_a(r_a), .i_q(r_q), .i_m(r_m), .o_a(w_step_a), .o_q(w_step_q)
  );

  always_ff @(posedge clk) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (r_cnt == LAST) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // busy covers the whole run up to the done cycle; done is the DONE state delayed one edge.
  always_comb begin
    w_busy_nxt = (w_next == CALC) || (w_next == FIX) || (w_next == DONE);
    w_done_nxt = (r_state == DONE);
  end

  always_comb begin
    w_dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
    w_dvs_abs = divisor[WIDTH-1]  ? -divisor  : divisor;
    w_rem_mag = r_a[WIDTH] ? (r_a[WIDTH-1:0] + r_m[WIDTH-1:0]) : r_a[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      case (r_state)
        IDLE: if (start) begin
          r_a     <= '0;
          r_q     <= w_dvd_abs;
          r_m     <= {1'b0, w_dvs_abs};
          r_cnt   <= '0;
          r_neg_r <= dividend[WIDTH-1];
          r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        end
        CALC: begin
          r_a   <= w_step_a;
          r_q   <= w_step_q;
          r_cnt <= r_cnt + CW'(1);
        end
        // With M=0 every step subtracts nothing, so A ends as |dividend| and the
        // signed remainder path reproduces the original dividend.
        FIX: begin
          r_dbz  <= (r_m == '0);
          r_quot <= (r_m == '0) ? '1 : (r_neg_q ? -r_q : r_q);
          r_rem  <= r_neg_r ? -w_rem_mag : w_rem_mag;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign o_state     = r_state;
endmodule
